// File: rtl/board_mem_pkg.sv
// Shared types and constants for the Life board memory arbiter.
package board_mem_pkg;

    localparam int BOARD_ADDR_W = 11;

    localparam logic [7:0] CTR_MAX = 8'hFF;

    typedef enum logic [1:0] {
        CLI_VIDEO  = 2'd0,
        CLI_ENGINE = 2'd1,
        CLI_LOADER = 2'd2
    } client_id_e;

    typedef logic [1:0] tag_t;

    typedef struct packed {
        logic valid;
        tag_t id;
    } tag_stage_t;

endpackage

// File: rtl/board_mem_arbiter_wait_ctr.sv
// Saturating wait counter for one non-video client, with a starved flag.
module board_mem_wait_ctr
    import board_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic gnt,
    output logic starved
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [7:0] count;

    // Count cycles spent waiting; a grant or a dropped request restarts the wait
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (!req || gnt) begin
            count <= '0;
        end else if (count != CTR_MAX) begin
            count <= count + 8'd1;
        end
    end

    assign starved = req && (count >= LIMIT);

endmodule

// File: rtl/board_mem_arbiter.sv
// Single-port scheduler sharing the board RAM between video, engine and loader.
module board_mem_arbiter
    import board_mem_pkg::*;
#(
    parameter int ADDR_W       = BOARD_ADDR_W,
    parameter int STARVE_LIMIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    input  logic              eng_req,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic              eng_wdata,
    output logic              eng_gnt,
    output logic              eng_rvalid,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              ld_wdata,
    output logic              ld_gnt,
    output logic              rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wdata,
    input  logic              mem_rdata,
    output logic              vid_miss,
    output logic [7:0]        miss_count
);

    logic       eng_starved;
    logic       ld_starved;
    logic       starve_override;
    logic       rr_ptr;
    tag_stage_t tag_next;
    tag_stage_t tag_s1;
    tag_stage_t tag_s2;

    board_mem_wait_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_eng_wait (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (eng_req),
        .gnt     (eng_gnt),
        .starved (eng_starved)
    );

    board_mem_wait_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_ld_wait (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (ld_req),
        .gnt     (ld_gnt),
        .starved (ld_starved)
    );

    // Pick one winner: starved client first, then video, then engine/loader round-robin
    always_comb begin
        vid_gnt         = 1'b0;
        eng_gnt         = 1'b0;
        ld_gnt          = 1'b0;
        starve_override = eng_starved || ld_starved;
        if (eng_starved && ld_starved) begin
            if (rr_ptr) ld_gnt = 1'b1;
            else        eng_gnt = 1'b1;
        end else if (eng_starved) begin
            eng_gnt = 1'b1;
        end else if (ld_starved) begin
            ld_gnt = 1'b1;
        end else if (vid_req) begin
            vid_gnt = 1'b1;
        end else if (eng_req && ld_req) begin
            if (rr_ptr) ld_gnt = 1'b1;
            else        eng_gnt = 1'b1;
        end else if (eng_req) begin
            eng_gnt = 1'b1;
        end else if (ld_req) begin
            ld_gnt = 1'b1;
        end
    end

    assign vid_miss = vid_req && starve_override;

    // Register the granted command toward the RAM; address and data hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 1'b0;
        end else begin
            mem_en <= vid_gnt || eng_gnt || ld_gnt;
            mem_we <= (eng_gnt && eng_we) || ld_gnt;
            if (vid_gnt) begin
                mem_addr <= vid_addr;
            end else if (eng_gnt) begin
                mem_addr  <= eng_addr;
                mem_wdata <= eng_wdata;
            end else if (ld_gnt) begin
                mem_addr  <= ld_addr;
                mem_wdata <= ld_wdata;
            end
        end
    end

    // Build the tag for this cycle's grant; only reads are tracked
    always_comb begin
        tag_next.valid = vid_gnt || (eng_gnt && !eng_we);
        tag_next.id    = vid_gnt ? tag_t'(CLI_VIDEO) : tag_t'(CLI_ENGINE);
    end

    // Two-stage tag pipeline matching the command register plus the RAM read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_s1 <= '0;
            tag_s2 <= '0;
        end else begin
            tag_s1 <= tag_next;
            tag_s2 <= tag_s1;
        end
    end

    assign vid_rvalid = tag_s2.valid && (tag_s2.id == tag_t'(CLI_VIDEO));
    assign eng_rvalid = tag_s2.valid && (tag_s2.id == tag_t'(CLI_ENGINE));
    assign rdata      = tag_s2.valid && mem_rdata;

    // Round-robin pointer points away from the last engine/loader winner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (eng_gnt) begin
            rr_ptr <= 1'b1;
        end else if (ld_gnt) begin
            rr_ptr <= 1'b0;
        end
    end

    // Saturating tally of video requests pre-empted by a starvation override
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_count <= '0;
        end else if (vid_miss && (miss_count != CTR_MAX)) begin
            miss_count <= miss_count + 8'd1;
        end
    end

endmodule
